// File: rtl/wb_master_if.sv
// Host request/response and Wishbone bus signals of wb_master.
// The master modport is the view taken by wb_master itself; the slave modport
// is the opposite side (host plus Wishbone slave).
interface wb_master_if;
    // Host request side
    logic         req_valid;
    logic         req_ready;
    logic         req_we;
    logic [4:0]   req_adr;
    logic [127:0] req_data;

    // Host response side
    logic         rsp_valid;
    logic [127:0] rsp_data;
    logic         rsp_error;
    logic         rsp_timeout;

    // Wishbone side
    logic         strobe;
    logic         we_o;
    logic [4:0]   adr_o;
    logic [127:0] wb_data_o;
    logic [127:0] wb_data_i;
    logic         ack_i;
    logic         error_i;

    modport master (
        input  req_valid, req_we, req_adr, req_data,
        input  wb_data_i, ack_i, error_i,
        output req_ready,
        output rsp_valid, rsp_data, rsp_error, rsp_timeout,
        output strobe, we_o, adr_o, wb_data_o
    );

    modport slave (
        output req_valid, req_we, req_adr, req_data,
        output wb_data_i, ack_i, error_i,
        input  req_ready,
        input  rsp_valid, rsp_data, rsp_error, rsp_timeout,
        input  strobe, we_o, adr_o, wb_data_o
    );
endinterface

// File: rtl/wb_master.sv
// Single-transfer Wishbone master.
// Accepts one host request at a time, drives it onto the bus and returns a
// one-cycle completion pulse with read data / error status. Writes to the
// exec addresses (16 = cmd exec, 19 = data exec) use a two-phase handshake:
// a first ack, ack low, then a completion ack, with strobe held throughout.
// Optional ack timeout: define WB_MASTER_TIMEOUT_EN to enable it
// (limit set by TIMEOUT_CYCLES); without it the master waits indefinitely.
module wb_master #(
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic        clock,
    input  logic        reset,
    wb_master_if.master bus
);

    typedef enum logic [2:0] {
        IDLE,
        STROBE,
        ACK_LOW,
        DONE_WAIT,
        RELEASE
    } state_t;

    state_t       state;
    logic         strobe_q;
    logic         we_q;
    logic [4:0]   adr_q;
    logic [127:0] wdat_q;
    logic         valid_q;
    logic [127:0] rdat_q;
    logic         err_q;

    logic busy;
    logic is_exec;
    logic complete_now;
    logic timed_out;

`ifdef WB_MASTER_TIMEOUT_EN
    // Counter value seen in the last cycle before the limit is reached.
    localparam logic [15:0] LIMIT = 16'(TIMEOUT_CYCLES - 1);

    logic [15:0] cnt_q;
    logic        tmo_q;
`endif

    assign busy    = (state == STROBE) || (state == ACK_LOW) || (state == DONE_WAIT);
    assign is_exec = we_q && ((adr_q == 5'd16) || (adr_q == 5'd19));

    // An ack finishes the transfer in STROBE unless it is the first, error-free
    // ack of an exec write; in DONE_WAIT any ack finishes it.
    assign complete_now = bus.ack_i &&
                          (((state == STROBE) && (!is_exec || bus.error_i)) ||
                           (state == DONE_WAIT));

`ifdef WB_MASTER_TIMEOUT_EN
    assign timed_out = busy && !bus.ack_i && (cnt_q >= LIMIT);
`else
    assign timed_out = 1'b0;
`endif

    // Transfer sequencing with all bus and response outputs registered
    always_ff @(posedge clock) begin
        if (!reset) begin
            state    <= IDLE;
            strobe_q <= 1'b0;
            we_q     <= 1'b0;
            adr_q    <= '0;
            wdat_q   <= '0;
            valid_q  <= 1'b0;
            rdat_q   <= '0;
            err_q    <= 1'b0;
`ifdef WB_MASTER_TIMEOUT_EN
            cnt_q    <= '0;
            tmo_q    <= 1'b0;
`endif
        end else begin
            valid_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        state    <= STROBE;
                        strobe_q <= 1'b1;
                        we_q     <= bus.req_we;
                        adr_q    <= bus.req_adr;
                        wdat_q   <= bus.req_data;
`ifdef WB_MASTER_TIMEOUT_EN
                        cnt_q    <= '0;
`endif
                    end
                end

                STROBE, ACK_LOW, DONE_WAIT: begin
`ifdef WB_MASTER_TIMEOUT_EN
                    // Saturate so a long-held ack cannot wrap the counter.
                    if (cnt_q != '1) begin
                        cnt_q <= cnt_q + 16'd1;
                    end
`endif
                    if (complete_now) begin
                        state    <= RELEASE;
                        strobe_q <= 1'b0;
                        valid_q  <= 1'b1;
                        rdat_q   <= we_q ? '0 : bus.wb_data_i;
                        err_q    <= bus.error_i;
`ifdef WB_MASTER_TIMEOUT_EN
                        tmo_q    <= 1'b0;
`endif
                    end else if ((state == STROBE) && bus.ack_i) begin
                        state <= ACK_LOW;
                    end else if (timed_out) begin
                        state    <= RELEASE;
                        strobe_q <= 1'b0;
                        valid_q  <= 1'b1;
                        rdat_q   <= '0;
                        err_q    <= 1'b1;
`ifdef WB_MASTER_TIMEOUT_EN
                        tmo_q    <= 1'b1;
`endif
                    end else if ((state == ACK_LOW) && !bus.ack_i) begin
                        state <= DONE_WAIT;
                    end
                end

                RELEASE: begin
                    state <= IDLE;
                end

                default: begin
                    state    <= IDLE;
                    strobe_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.req_ready = (state == IDLE);
    assign bus.strobe    = strobe_q;
    assign bus.we_o      = we_q;
    assign bus.adr_o     = adr_q;
    assign bus.wb_data_o = wdat_q;
    assign bus.rsp_valid = valid_q;
    assign bus.rsp_data  = rdat_q;
    assign bus.rsp_error = err_q;
`ifdef WB_MASTER_TIMEOUT_EN
    assign bus.rsp_timeout = tmo_q;
`else
    assign bus.rsp_timeout = 1'b0;
`endif

endmodule
